// File: rtl/sd_bd_queue_pkg.sv
// Shared constants for the SD buffer-descriptor queues.
//   BD_SIZE        : descriptor storage depth in 32-bit words
//   BD_WIDTH       : width of the free-slot counter
//   RAM_MEM_WIDTH  : descriptor word width
//   BD_EMPTY       : free count of an empty queue (two words per descriptor)
//   BD_WORD_*      : word offsets inside one descriptor
package sd_bd_queue_pkg;
  localparam int BD_SIZE        = 16;
  localparam int BD_WIDTH       = 5;
  localparam int RAM_MEM_WIDTH  = 32;
  localparam int BD_EMPTY       = BD_SIZE / 2;
  localparam int BD_WORD_SYSADR = 0;
  localparam int BD_WORD_ARG    = 1;
endpackage

// File: rtl/sd_bd_ram.sv
// Simple dual-port RAM, one write port, one synchronous read port.
//   clk, rst_n          : clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i: write port
//   re_i/raddr_i        : read request; data appears on rdata_o next cycle
//   rdata_o             : read data, holds until the next read
module sd_bd_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Output register is reset so the consumer sees zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/sd_bd_queue.sv
// Buffer-descriptor queue between host registers and the SD data master.
// A descriptor is two words: sys_adr then cmd_arg.
//   clk, rst_n        : clock, async active-low reset
//   we_bd, dat_bd_i   : host word write
//   bd_clr            : synchronous flush (highest priority)
//   free_bd           : free descriptor slots
//   wr_ovf            : pulse, host write dropped because full
//   re_s, ack_o_s     : master read request / per-word ack (dat_out valid with ack)
//   dat_out           : descriptor word, holds between acks
//   a_cmp, cmp_err    : completion pulse / pulse when completing an empty queue
module sd_bd_queue #(
  parameter int BD_SIZE  = sd_bd_queue_pkg::BD_SIZE,
  parameter int BD_WIDTH = sd_bd_queue_pkg::BD_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_bd,
  input  logic [31:0]         dat_bd_i,
  input  logic                bd_clr,
  output logic [BD_WIDTH-1:0] free_bd,
  output logic                wr_ovf,
  input  logic                re_s,
  output logic                ack_o_s,
  output logic [31:0]         dat_out,
  input  logic                a_cmp,
  output logic                cmp_err
);
  import sd_bd_queue_pkg::*;

  localparam int AW = $clog2(BD_SIZE);
  localparam logic [BD_WIDTH-1:0] FREE_ALL = BD_WIDTH'(BD_SIZE / 2);

  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_base_q, rd_base_d;
  logic                wr_phase_q, wr_phase_d;
  logic [1:0]          rd_idx_q, rd_idx_d;
  logic [BD_WIDTH-1:0] free_q, free_d;
  logic                ack_q, ovf_q, cerr_q;
  logic                has_desc, wr_acc, commit, cmp_ok, rd_issue;
  logic [AW-1:0]       rd_addr;

  assign has_desc = (free_q != FREE_ALL);
  assign wr_acc   = we_bd && (free_q != '0) && !bd_clr;
  assign commit   = wr_acc && wr_phase_q;
  assign cmp_ok   = a_cmp && has_desc && !bd_clr;
  // One read outstanding at a time: skip the cycle the previous word is acked,
  // so acks are never back to back. rd_idx==2 blocks further reads until re_s drops.
  assign rd_issue = re_s && has_desc && !rd_idx_q[1] && !ack_q && !bd_clr;
  assign rd_addr  = rd_base_q + AW'(rd_idx_q);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    wr_phase_d = wr_phase_q;
    rd_base_d  = rd_base_q;
    rd_idx_d   = rd_idx_q;
    free_d     = free_q;
    if (bd_clr) begin
      wr_ptr_d   = '0;
      wr_phase_d = 1'b0;
      rd_base_d  = '0;
      rd_idx_d   = 2'(BD_WORD_SYSADR);
      free_d     = FREE_ALL;
    end else begin
      if (wr_acc) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        wr_phase_d = ~wr_phase_q;
      end
      if (cmp_ok) rd_base_d = rd_base_q + AW'(BD_WORD_ARG + 1);
      // rd_idx survives a_cmp; only dropping re_s rewinds it (retry support).
      if (!re_s)         rd_idx_d = 2'(BD_WORD_SYSADR);
      else if (rd_issue) rd_idx_d = rd_idx_q + 2'd1;
      case ({commit, cmp_ok})
        2'b10:   free_d = free_q - BD_WIDTH'(1);
        2'b01:   free_d = free_q + BD_WIDTH'(1);
        default: free_d = free_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      wr_phase_q <= 1'b0;
      rd_base_q  <= '0;
      rd_idx_q   <= '0;
      free_q     <= FREE_ALL;
      ack_q      <= 1'b0;
      ovf_q      <= 1'b0;
      cerr_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      wr_phase_q <= wr_phase_d;
      rd_base_q  <= rd_base_d;
      rd_idx_q   <= rd_idx_d;
      free_q     <= free_d;
      ack_q      <= rd_issue;
      ovf_q      <= we_bd && (free_q == '0) && !bd_clr;
      cerr_q     <= a_cmp && !has_desc && !bd_clr;
    end
  end

  sd_bd_ram #(
    .DEPTH (BD_SIZE),
    .WIDTH (RAM_MEM_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (dat_bd_i),
    .re_i    (rd_issue),
    .raddr_i (rd_addr),
    .rdata_o (dat_out)
  );

  assign free_bd = free_q;
  assign ack_o_s = ack_q;
  assign wr_ovf  = ovf_q;
  assign cmp_err = cerr_q;
endmodule

// File: tb/tb_sd_bd_queue.sv
module tb_sd_bd_queue;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        we_bd = 1'b0, bd_clr = 1'b0, re_s = 1'b0, a_cmp = 1'b0;
  logic [31:0] dat_bd_i = '0;
  logic [4:0]  free_bd;
  logic        wr_ovf, ack_o_s, cmp_err;
  logic [31:0] dat_out;

  int checks = 0, errors = 0;
  int ack_cnt = 0, cyc = 0, last_ack = 0;
  logic [31:0] exp_q[$];    // scoreboard of words the master should receive
  logic [63:0] model_q[$];  // committed descriptors {sys_adr, cmd_arg}

  sd_bd_queue dut (
    .clk(clk), .rst_n(rst_n), .we_bd(we_bd), .dat_bd_i(dat_bd_i), .bd_clr(bd_clr),
    .free_bd(free_bd), .wr_ovf(wr_ovf), .re_s(re_s), .ack_o_s(ack_o_s),
    .dat_out(dat_out), .a_cmp(a_cmp), .cmp_err(cmp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Ack monitor: every ack pops one expected word; the two words of a pair are 2 cycles apart.
  always @(negedge clk) begin
    if (ack_o_s === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_ack: got ack with data %h want no ack", dat_out);
      end
      if (exp_q.size() != 0) chk("ack_data", dat_out, exp_q.pop_front());
      if (ack_cnt % 2 == 1) chk("ack_gap", cyc - last_ack, 2);
      last_ack = cyc;
      ack_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_word(input logic [31:0] d);
    dat_bd_i = d; we_bd = 1'b1; tick(); we_bd = 1'b0;
  endtask

  task automatic wr_desc(input logic [31:0] a, input logic [31:0] c);
    wr_word(a); wr_word(c); model_q.push_back({a, c});
  endtask

  task automatic wait_acks(input int target);
    int n = 0;
    while (ack_cnt < target && n < 40) begin tick(); n++; end
    chk("ack_timeout", 32'(ack_cnt >= target), 32'd1);
  endtask

  // Read the head descriptor, then hold re_s 4 more cycles: no third ack allowed.
  task automatic read_head(input string tag);
    int target;
    exp_q.push_back(model_q[0][63:32]);
    exp_q.push_back(model_q[0][31:0]);
    target = ack_cnt + 2;
    re_s = 1'b1;
    wait_acks(target);
    repeat (4) tick();
    chk({tag, "_no_third_ack"}, ack_cnt, target);
    re_s = 1'b0;
    tick();
  endtask

  task automatic complete();
    a_cmp = 1'b1; tick(); a_cmp = 1'b0;
    void'(model_q.pop_front());
  endtask

  initial begin
    int base;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_free", free_bd, 8);
    chk("rst_dat", dat_out, 0);
    chk("rst_ack", ack_o_s, 0);
    chk("rst_ovf", wr_ovf, 0);
    chk("rst_cerr", cmp_err, 0);

    // Fill path
    wr_word(32'h0000_1000);
    chk("free_w0", free_bd, 8);
    wr_word(32'h0000_0200);
    model_q.push_back({32'h0000_1000, 32'h0000_0200});
    chk("free_w1", free_bd, 7);
    chk("ovf_fill", wr_ovf, 0);

    // Read, then retry of the same descriptor
    read_head("rd1");
    read_head("retry");
    complete();
    chk("free_cmp", free_bd, 8);
    base = ack_cnt;
    re_s = 1'b1;
    repeat (5) tick();
    chk("no_ack_empty", ack_cnt, base);
    re_s = 1'b0;
    tick();

    // Full / overflow
    for (int i = 0; i < 8; i++) wr_desc(32'hA000_0000 + 2 * i, 32'hA000_0001 + 2 * i);
    chk("free_full", free_bd, 0);
    dat_bd_i = 32'hDEAD_BEEF; we_bd = 1'b1; tick(); we_bd = 1'b0;
    chk("ovf_pulse", wr_ovf, 1);
    chk("free_ovf", free_bd, 0);
    tick();
    chk("ovf_clear", wr_ovf, 0);
    read_head("full_read");
    complete();
    chk("free_full_cmp", free_bd, 1);
    wr_desc(32'hB000_0000, 32'hB000_0001);
    chk("free_refull", free_bd, 0);
    complete();
    chk("free_cmp2", free_bd, 1);
    // Commit and completion in the same cycle: free count unchanged
    wr_word(32'hC000_0000);
    dat_bd_i = 32'hC000_0001; we_bd = 1'b1; a_cmp = 1'b1; tick();
    we_bd = 1'b0; a_cmp = 1'b0;
    void'(model_q.pop_front());
    model_q.push_back({32'hC000_0000, 32'hC000_0001});
    chk("free_commit_cmp", free_bd, 1);
    while (model_q.size() != 0) begin read_head("drain"); complete(); end
    chk("free_drained", free_bd, 8);

    // Wrap
    for (int i = 0; i < 20; i++) begin
      wr_desc(32'h5000_0000 + i, 32'h6000_0000 + i);
      read_head("wrap");
      complete();
    end
    chk("free_wrap", free_bd, 8);

    // Clear discards a half-written descriptor
    wr_word(32'hBAD0_0001);
    bd_clr = 1'b1; tick(); bd_clr = 1'b0;
    chk("free_clr", free_bd, 8);
    wr_desc(32'h0000_7777, 32'h0000_8888);
    chk("free_after_clr", free_bd, 7);
    read_head("clr_read");
    complete();

    // Completion on an empty queue
    a_cmp = 1'b1; tick(); a_cmp = 1'b0;
    chk("cerr_pulse", cmp_err, 1);
    chk("free_cerr", free_bd, 8);
    tick();
    chk("cerr_clear", cmp_err, 0);

    // Reset while the second word's ack is on the bus
    wr_desc(32'hE000_0000, 32'hE000_0001);
    exp_q.push_back(32'hE000_0000);
    exp_q.push_back(32'hE000_0001);
    base = ack_cnt;
    re_s = 1'b1;
    wait_acks(base + 1);
    tick();
    chk("pre_rst_ack", ack_o_s, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", ack_o_s, 0);
    chk("rst_mid_free", free_bd, 8);
    chk("rst_mid_dat", dat_out, 0);
    exp_q.delete();
    model_q.delete();
    re_s = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
